// File: rtl/wb_gpio_pkg.sv
// wb_gpio_pkg: register map and byte-lane write helper shared by the GPIO block
package wb_gpio_pkg;
    localparam int ADDR_LSB = 2;
    localparam logic [2:0] REG_DATA_IN    = 3'd0;
    localparam logic [2:0] REG_DATA_OUT   = 3'd1;
    localparam logic [2:0] REG_DIR        = 3'd2;
    localparam logic [2:0] REG_IRQ_MASK   = 3'd3;
    localparam logic [2:0] REG_IRQ_EDGE   = 3'd4;
    localparam logic [2:0] REG_IRQ_STATUS = 3'd5;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v, input logic [31:0] new_v,
                                                input logic [3:0] sel);
        logic [31:0] m;
        for (int n = 0; n < 4; n++) m[8*n+:8] = sel[n] ? new_v[8*n+:8] : old_v[8*n+:8];
        return m;
    endfunction
endpackage

// File: rtl/gpio_sync_edge.sv
// gpio_sync_edge: two-flop pad synchronizer with per-bit rise/fall detection
module gpio_sync_edge #(
    parameter int GPIO_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [GPIO_WIDTH-1:0] gpio_i,
    output logic [GPIO_WIDTH-1:0] sync_o,
    output logic [GPIO_WIDTH-1:0] rise_o,
    output logic [GPIO_WIDTH-1:0] fall_o
);
    logic [GPIO_WIDTH-1:0] meta_q, sync_q, prev_q;
    logic [1:0] warm_q, warm_d;
    logic live;

    // Events stay off until sync and prev both hold real pad samples.
    always_comb begin
        live = warm_q == 2'd3;
        warm_d = live ? warm_q : warm_q + 2'd1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
            warm_q <= 2'd0;
        end else begin
            meta_q <= gpio_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
            warm_q <= warm_d;
        end
    end

    assign sync_o = sync_q;
    assign rise_o = live ? sync_q & ~prev_q : '0;
    assign fall_o = live ? ~sync_q & prev_q : '0;
endmodule

// File: rtl/wb_gpio.sv
// wb_gpio: Wishbone B3 classic GPIO responder with direction, output data and edge interrupts
module wb_gpio
    import wb_gpio_pkg::*;
#(
    parameter int GPIO_WIDTH = 8,
    parameter int ADDR_WIDTH = 5,
    parameter logic [GPIO_WIDTH-1:0] OUT_RESET = '0,
    parameter logic [GPIO_WIDTH-1:0] DIR_RESET = '0
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic [ADDR_WIDTH-1:0] wb_adr_i,
    input  logic [31:0]           wb_dat_i,
    input  logic [3:0]            wb_sel_i,
    input  logic                  wb_we_i,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    output logic [31:0]           wb_dat_o,
    output logic                  wb_ack_o,
    output logic                  wb_err_o,
    input  logic [GPIO_WIDTH-1:0] gpio_i,
    output logic [GPIO_WIDTH-1:0] gpio_o,
    output logic [GPIO_WIDTH-1:0] gpio_oe,
    output logic                  irq_o
);
    localparam int W = GPIO_WIDTH;

    logic [W-1:0] sync, rise, fall, evt, w1c;
    logic [W-1:0] out_q, out_d, dir_q, dir_d, mask_q, mask_d, edge_q, edge_d, stat_q, stat_d;
    logic [31:0] dat_q, dat_d, rd_val;
    logic ack_q, ack_d, irq_q, irq_d, req, wr;
    logic [2:0] idx;
    logic unused_adr;

    function automatic logic [31:0] ext(input logic [W-1:0] v);
        logic [31:0] r;
        r = '0;
        r[W-1:0] = v;
        return r;
    endfunction

    gpio_sync_edge #(.GPIO_WIDTH(W)) u_sync (
        .clk_i (wb_clk_i),
        .rst_i (wb_rst_i),
        .gpio_i(gpio_i),
        .sync_o(sync),
        .rise_o(rise),
        .fall_o(fall)
    );

    // Writes commit on the edge that closes the ack cycle, so a reset during ack drops them.
    always_comb begin
        idx = wb_adr_i[ADDR_LSB+:3];
        req = wb_cyc_i & wb_stb_i & ~ack_q;
        wr = ack_q & wb_cyc_i & wb_stb_i & wb_we_i;
        evt = (edge_q & rise) | (~edge_q & fall);
        out_d = (wr && idx == REG_DATA_OUT) ? W'(merge_bytes(ext(out_q), wb_dat_i, wb_sel_i)) : out_q;
        dir_d = (wr && idx == REG_DIR) ? W'(merge_bytes(ext(dir_q), wb_dat_i, wb_sel_i)) : dir_q;
        mask_d = (wr && idx == REG_IRQ_MASK) ? W'(merge_bytes(ext(mask_q), wb_dat_i, wb_sel_i)) : mask_q;
        edge_d = (wr && idx == REG_IRQ_EDGE) ? W'(merge_bytes(ext(edge_q), wb_dat_i, wb_sel_i)) : edge_q;
        w1c = (wr && idx == REG_IRQ_STATUS) ? W'(merge_bytes('0, wb_dat_i, wb_sel_i)) : '0;
        stat_d = (stat_q & ~w1c) | evt;
        rd_val = idx == REG_DATA_IN    ? ext(sync)   :
                 idx == REG_DATA_OUT   ? ext(out_q)  :
                 idx == REG_DIR        ? ext(dir_q)  :
                 idx == REG_IRQ_MASK   ? ext(mask_q) :
                 idx == REG_IRQ_EDGE   ? ext(edge_q) :
                 idx == REG_IRQ_STATUS ? ext(stat_q) : '0;
        dat_d = (req && !wb_we_i) ? rd_val : '0;
        ack_d = req;
        irq_d = |(stat_q & mask_q);
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            out_q <= OUT_RESET;
            dir_q <= DIR_RESET;
            mask_q <= '0;
            edge_q <= '0;
            stat_q <= '0;
            dat_q <= '0;
            ack_q <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            out_q <= out_d;
            dir_q <= dir_d;
            mask_q <= mask_d;
            edge_q <= edge_d;
            stat_q <= stat_d;
            dat_q <= dat_d;
            ack_q <= ack_d;
            irq_q <= irq_d;
        end
    end

    assign unused_adr = ^wb_adr_i;
    assign wb_ack_o = ack_q & wb_cyc_i;
    assign wb_dat_o = wb_cyc_i ? dat_q : '0;
    assign wb_err_o = 1'b0;
    assign gpio_o = out_q;
    assign gpio_oe = dir_q;
    assign irq_o = irq_q;
endmodule

// File: tb/tb_wb_gpio.sv
// tb_wb_gpio: randomized self-checking bench for wb_gpio against a register-level model
module tb_wb_gpio;
    logic clk = 1'b0, rst = 1'b1;
    logic [4:0] wb_adr_i = '0;
    logic [31:0] wb_dat_i = '0, wb_dat_o;
    logic [3:0] wb_sel_i = '0;
    logic wb_we_i = 1'b0, wb_cyc_i = 1'b0, wb_stb_i = 1'b0;
    logic wb_ack_o, wb_err_o, irq_o;
    logic [7:0] gpio_i = 8'hC3, gpio_o, gpio_oe;
    int checks = 0, errors = 0;
    bit err_seen = 1'b0;

    logic [7:0] pins = 8'hC3, m_out = '0, m_dir = '0, m_mask = '0, m_edge = '0, m_stat = '0;

    wb_gpio dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
        .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
        .gpio_i(gpio_i), .gpio_o(gpio_o), .gpio_oe(gpio_oe), .irq_o(irq_o)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (wb_err_o !== 1'b0) err_seen = 1'b1;

    function automatic logic [31:0] exp_rd(input logic [2:0] idx);
        logic [7:0] v;
        v = idx == 3'd0 ? pins : idx == 3'd1 ? m_out : idx == 3'd2 ? m_dir :
            idx == 3'd3 ? m_mask : idx == 3'd4 ? m_edge : idx == 3'd5 ? m_stat : 8'h00;
        return {24'h0, v};
    endfunction

    // Only byte lane 0 exists on an 8-pin block.
    task automatic model_write(input logic [2:0] idx, input logic [31:0] d, input logic [3:0] sel);
        if (sel[0]) begin
            if (idx == 3'd1) m_out = d[7:0];
            if (idx == 3'd2) m_dir = d[7:0];
            if (idx == 3'd3) m_mask = d[7:0];
            if (idx == 3'd4) m_edge = d[7:0];
            if (idx == 3'd5) m_stat = m_stat & ~d[7:0];
        end
    endtask

    task automatic bus(input logic we, input logic [2:0] idx, input logic [31:0] d, input logic [3:0] sel,
                       output logic [31:0] rd, output int lat);
        wb_adr_i = {idx, 2'b00};
        wb_dat_i = d;
        wb_sel_i = sel;
        wb_we_i = we;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (wb_ack_o !== 1'b1 && lat < 8);
        rd = wb_dat_o;
        if (wb_ack_o !== 1'b1) begin
            checks++; errors++; lat = 99;
            $display("FAIL bus_timeout idx %0d got no ack want ack", idx);
        end
        @(posedge clk); #1;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i = 1'b0;
        if (we) model_write(idx, d, sel);
    endtask

    task automatic set_pins(input logic [7:0] v);
        m_stat = m_stat | (m_edge & v & ~pins) | (~m_edge & ~v & pins);
        pins = v;
        gpio_i = v;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        int lat;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (wb_ack_o !== 1'b0) begin errors++; $display("FAIL rst_ack got %h want 0", wb_ack_o); end
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL rst_irq got %h want 0", irq_o); end
        checks++; if (gpio_o !== 8'h00) begin errors++; $display("FAIL rst_gpio_o got %h want 00", gpio_o); end
        checks++; if (gpio_oe !== 8'h00) begin errors++; $display("FAIL rst_gpio_oe got %h want 00", gpio_oe); end
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        bus(1'b0, 3'd2, 32'h0, 4'hF, rd, lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL rst_ack_latency got %0d want 1", lat); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rst_dir got %h want 00000000", rd); end
        bus(1'b0, 3'd5, 32'h0, 4'hF, rd, lat);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rst_status got %h want 00000000", rd); end
        bus(1'b0, 3'd0, 32'h0, 4'hF, rd, lat);
        checks++; if (rd !== 32'hC3) begin errors++; $display("FAIL rst_data_in got %h want 000000c3", rd); end
    endtask

    task automatic test_byte_lane();
        logic [31:0] rd;
        int lat;
        bus(1'b1, 3'd1, 32'h000000A5, 4'b0001, rd, lat);
        checks++; if (gpio_o !== 8'hA5) begin errors++; $display("FAIL lane_gpio_o got %h want a5", gpio_o); end
        bus(1'b1, 3'd1, 32'hFFFFFF00, 4'b1110, rd, lat);
        bus(1'b0, 3'd1, 32'h0, 4'hF, rd, lat);
        checks++; if (rd !== 32'hA5) begin errors++; $display("FAIL lane_readback got %h want 000000a5", rd); end
    endtask

    task automatic test_rise();
        logic [31:0] rd;
        int lat;
        set_pins(8'h00);
        bus(1'b1, 3'd5, 32'hFF, 4'h1, rd, lat);
        bus(1'b1, 3'd2, 32'h00, 4'h1, rd, lat);
        bus(1'b1, 3'd4, 32'h01, 4'h1, rd, lat);
        bus(1'b1, 3'd3, 32'h01, 4'h1, rd, lat);
        pins = 8'h01;
        gpio_i = pins;
        m_stat = 8'h01;
        @(posedge clk); #1;
        wb_adr_i = 5'h00; wb_we_i = 1'b0; wb_sel_i = 4'hF; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        @(posedge clk); #1;
        checks++; if (wb_ack_o !== 1'b1 || wb_dat_o !== 32'h0) begin errors++; $display("FAIL din_early got ack %h dat %h want ack 1 dat 0", wb_ack_o, wb_dat_o); end
        @(posedge clk); #1;
        checks++; if (wb_ack_o !== 1'b0 || irq_o !== 1'b0) begin errors++; $display("FAIL ack_gap got ack %h irq %h want 0 0", wb_ack_o, irq_o); end
        @(posedge clk); #1;
        checks++; if (wb_ack_o !== 1'b1 || wb_dat_o !== 32'h1) begin errors++; $display("FAIL din_sync got ack %h dat %h want ack 1 dat 1", wb_ack_o, wb_dat_o); end
        checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL rise_irq got %h want 1", irq_o); end
        @(posedge clk); #1;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        bus(1'b0, 3'd5, 32'h0, 4'hF, rd, lat);
        checks++; if (rd !== exp_rd(3'd5)) begin errors++; $display("FAIL rise_status got %h want %h", rd, exp_rd(3'd5)); end
    endtask

    task automatic test_w1c();
        logic [31:0] rd;
        int lat;
        bus(1'b1, 3'd5, 32'h01, 4'h1, rd, lat);
        checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL w1c_irq_hold got %h want 1", irq_o); end
        @(posedge clk); #1;
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL w1c_irq_clear got %h want 0", irq_o); end
        set_pins(8'h00);
        set_pins(8'h01);
        set_pins(8'h00);
        checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL w1c_irq_rearm got %h want 1", irq_o); end
        pins = 8'h01;
        gpio_i = pins;
        @(posedge clk); #1;
        bus(1'b1, 3'd5, 32'h01, 4'h1, rd, lat);
        m_stat = m_stat | 8'h01;
        checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL race_irq got %h want 1", irq_o); end
        @(posedge clk); #1;
        checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL race_irq_next got %h want 1", irq_o); end
        bus(1'b0, 3'd5, 32'h0, 4'hF, rd, lat);
        checks++; if (rd !== 32'h01) begin errors++; $display("FAIL race_status got %h want 00000001", rd); end
    endtask

    task automatic test_masked_fall();
        logic [31:0] rd;
        int lat;
        bus(1'b1, 3'd3, 32'h00, 4'h1, rd, lat);
        bus(1'b1, 3'd4, 32'h01, 4'h1, rd, lat);
        set_pins(8'h09);
        bus(1'b1, 3'd5, 32'hFF, 4'h1, rd, lat);
        set_pins(8'h01);
        bus(1'b0, 3'd5, 32'h0, 4'hF, rd, lat);
        checks++; if (rd !== 32'h08) begin errors++; $display("FAIL fall_status got %h want 00000008", rd); end
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL fall_irq_masked got %h want 0", irq_o); end
        bus(1'b1, 3'd3, 32'h08, 4'h1, rd, lat);
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL mask_irq_lag got %h want 0", irq_o); end
        @(posedge clk); #1;
        checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL mask_irq got %h want 1", irq_o); end
    endtask

    task automatic test_back_to_back();
        int acks;
        acks = 0;
        wb_adr_i = 5'h04; wb_dat_i = 32'h3C; wb_sel_i = 4'h1; wb_we_i = 1'b1; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (wb_ack_o === 1'b1) acks++;
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        m_out = 8'h3C;
        checks++; if (acks !== 3) begin errors++; $display("FAIL b2b_acks got %0d want 3", acks); end
        checks++; if (gpio_o !== 8'h3C) begin errors++; $display("FAIL b2b_gpio_o got %h want 3c", gpio_o); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        int lat;
        wb_adr_i = 5'h04; wb_dat_i = 32'h5A; wb_sel_i = 4'h1; wb_we_i = 1'b1; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        @(posedge clk); #1;
        checks++; if (wb_ack_o !== 1'b1) begin errors++; $display("FAIL midrst_ack_pre got %h want 1", wb_ack_o); end
        rst = 1'b1;
        #1;
        checks++; if (wb_ack_o !== 1'b0) begin errors++; $display("FAIL midrst_ack got %h want 0", wb_ack_o); end
        checks++; if (gpio_o !== 8'h00) begin errors++; $display("FAIL midrst_gpio_o got %h want 00", gpio_o); end
        repeat (2) @(posedge clk);
        #1;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        rst = 1'b0;
        {m_out, m_dir, m_mask, m_edge, m_stat} = '0;
        repeat (2) @(posedge clk);
        #1;
        bus(1'b0, 3'd1, 32'h0, 4'hF, rd, lat);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL midrst_data_out got %h want 00000000", rd); end
    endtask

    task automatic test_random();
        logic [31:0] rd, d;
        logic [2:0] idx;
        int lat;
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 2) == 0) set_pins(8'($urandom));
            else begin
                idx = 3'($urandom_range(0, 7));
                d = $urandom;
                bus(1'b1, idx, d, 4'($urandom), rd, lat);
            end
            idx = 3'($urandom_range(0, 7));
            bus(1'b0, idx, 32'h0, 4'hF, rd, lat);
            checks++; if (rd !== exp_rd(idx)) begin errors++; $display("FAIL rand_read it %0d idx %0d got %h want %h", it, idx, rd, exp_rd(idx)); end
            checks++; if (gpio_o !== m_out || gpio_oe !== m_dir) begin errors++; $display("FAIL rand_pins it %0d got %h/%h want %h/%h", it, gpio_o, gpio_oe, m_out, m_dir); end
            checks++; if (irq_o !== |(m_stat & m_mask)) begin errors++; $display("FAIL rand_irq it %0d got %h want %h", it, irq_o, |(m_stat & m_mask)); end
        end
    endtask

    initial begin
        test_reset();
        test_byte_lane();
        test_rise();
        test_w1c();
        test_masked_fall();
        test_back_to_back();
        test_reset_mid();
        test_random();
        checks++; if (err_seen !== 1'b0) begin errors++; $display("FAIL wb_err got 1 want 0"); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end
endmodule

// File: doc/wb_gpio.md
Name: wb_gpio

Overview:
- Wishbone B3 classic responder that exposes the board's general-purpose pins (IO[7:0], LEDs) to the picorv32 Wishbone initiator as memory-mapped registers.
- Provides per-pin direction, output data, synchronized input sampling and edge-triggered interrupts.
- Sits on the SoC data bus beside the UART and SDRAM slaves, clocked by wb_clk.
- Pad tristating (gpio_o/gpio_oe to inout) is done at the board top level.

Parameters:
- GPIO_WIDTH, 8, number of pins (1..32).
- ADDR_WIDTH, 5, width of wb_adr_i (byte address; registers are word-aligned).
- OUT_RESET, 0, reset value of the DATA_OUT register (GPIO_WIDTH bits).
- DIR_RESET, 0, reset value of the DIR register (1 = output).

Ports:
- wb_clk_i  in  1  bus clock; the only clock.
- wb_rst_i  in  1  asynchronous, active-high reset.
- wb_adr_i  in  ADDR_WIDTH  byte address.
- wb_dat_i  in  32  write data.
- wb_sel_i  in  4  byte selects.
- wb_we_i  in  1  write enable.
- wb_cyc_i  in  1  cycle valid.
- wb_stb_i  in  1  strobe.
- wb_dat_o  out  32  read data.
- wb_ack_o  out  1  transfer acknowledge.
- wb_err_o  out  1  tied 0.
- gpio_i  in  GPIO_WIDTH  asynchronous pad inputs.
- gpio_o  out  GPIO_WIDTH  output data to pads.
- gpio_oe  out  GPIO_WIDTH  per-pin output enable.
- irq_o  out  1  level interrupt to CPU.

Behaviour:
- Register map, at wb_adr_i[4:2]; unused upper bits read 0:
  - 0 DATA_IN (RO): synchronized gpio_i.
  - 1 DATA_OUT (RW).
  - 2 DIR (RW).
  - 3 IRQ_MASK (RW).
  - 4 IRQ_EDGE (RW; 1 = rising, 0 = falling).
  - 5 IRQ_STATUS (read; write-1-to-clear).
  - 6, 7: read 0, writes ignored, still acked.
- Handshake:
  - Request = wb_cyc_i & wb_stb_i & ~wb_ack_o.
  - wb_ack_o is registered and asserts exactly 1 cycle after the request is seen, for 1 cycle.
  - A master holding stb gets one ack every 2 cycles.
  - Ack drops immediately if cyc falls.
- Writes commit on the ack edge. Only bytes with wb_sel_i[n]=1 update bits [8n+7:8n]. Writes to DATA_IN are ignored.
- wb_dat_o is registered alongside ack (valid while ack=1) and holds 0 otherwise.
- gpio_o = DATA_OUT; gpio_oe = DIR. Both are registered with no extra latency after the write commits.
- Input path:
  - 2-flop synchronizer into sync, plus a prev register; DATA_IN = sync.
  - Input change to DATA_IN visibility: 2 cycles.
- Edge event per bit: rise = sync & ~prev; fall = ~sync & prev; event = IRQ_EDGE ? rise : fall.
- IRQ_STATUS bit sets on an event regardless of mask; masked bits still latch.
- Simultaneous W1C and new event on the same bit in the same cycle: the set wins and the bit stays 1.
- irq_o = |(IRQ_STATUS & IRQ_MASK), registered, so 1 cycle after the status/mask change.
- Reset values:
  - DATA_OUT = OUT_RESET, DIR = DIR_RESET.
  - MASK, EDGE, STATUS = 0.
  - sync and prev = 0.
  - wb_ack_o, wb_dat_o, irq_o = 0.
- Reset mid-transfer: ack and data clear asynchronously and the pending write is dropped.
- Edge-detect spurious rising event on the first cycles after reset is suppressed: prev is loaded from sync during the first 2 post-reset cycles (2-bit warm-up counter) and no events are generated then.

Decomposition:
- Shared package wb_gpio_pkg:
  - register index constants REG_DATA_IN..REG_IRQ_STATUS.
  - ADDR_LSB=2.
  - a byte-lane write-merge function (old, new, sel) -> merged.
- One natural sub-module: gpio_sync_edge (2-flop sync, prev, warm-up counter, rise/fall outputs), parameterized by GPIO_WIDTH.
- Register file and bus logic stay in wb_gpio.

Test Plan:
- Reset values: hold reset, release → gpio_oe=00, gpio_o=00, irq_o=0; read DIR→0x00000000 with ack exactly 1 cycle after stb; wb_err_o stays 0 throughout.
- Byte-lane write: write DATA_OUT 0x000000A5 with sel=4'b0001, then 0xFFFFFF00 with sel=4'b1110 → readback 0x000000A5; gpio_o=0xA5 on the cycle after the first ack.
- Input sync and rising edge: set DIR=0x00, EDGE=0x01, MASK=0x01; drive gpio_i[0] 0→1 → DATA_IN reads 0x01 after 2 cycles; STATUS=0x01; irq_o=1.
- W1C: write STATUS 0x01 → irq_o=0 one cycle later. Repeat with a fresh edge on the same cycle as the W1C ack → STATUS stays 0x01 and irq_o stays 1.
- Masked and falling edge: MASK=0, EDGE[3]=0, gpio_i[3] 1→0 → STATUS=0x08, irq_o=0; then set MASK=0x08 → irq_o=1.
- Back-to-back and reset: stb held for 6 cycles → exactly 3 acks. Assert reset on an ack cycle of a DATA_OUT write of 0x5A → ack clears at once; DATA_OUT = OUT_RESET.
